// File: rtl/sccb_write_master.sv
// Three-byte SCCB write engine: START, 3x(8 data + ACK), STOP on open-drain SDA.
// Quarter-bit tick from an internal divider; four-phase GO/END handshake.
module sccb_write_master #(
  parameter int CLK_FREQ = 12500000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int T  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int DW = $clog2(T);

  typedef enum logic [2:0] {
    IDLE, START, BIT, STOP, DONE
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div, div_n;
  logic [1:0]    q, q_n;
  logic [4:0]    bcnt, bcnt_n;
  logic [23:0]   shreg, shreg_n;
  logic          scl, scl_n;
  logic          sda_low, sda_low_n;
  logic          nack, nack_n;
  logic          end_r, end_n;
  logic          ack_r, ack_n;
  logic          busy_r, busy_n;
  logic          tick;
  logic          ack_slot;

  assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;
  assign I2C_SCLK = scl;
  assign oEND     = end_r;
  assign oACK     = ack_r;
  assign oBUSY    = busy_r;

  assign tick     = (div == DW'(T - 1));
  assign ack_slot = (bcnt == 5'd8) || (bcnt == 5'd17) ||
                    (bcnt == 5'd26);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      div     <= '0;
      q       <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      scl     <= 1'b1;
      sda_low <= 1'b0;
      nack    <= 1'b0;
      end_r   <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      q       <= q_n;
      bcnt    <= bcnt_n;
      shreg   <= shreg_n;
      scl     <= scl_n;
      sda_low <= sda_low_n;
      nack    <= nack_n;
      end_r   <= end_n;
      ack_r   <= ack_n;
      busy_r  <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_n     = div;
    q_n       = q;
    bcnt_n    = bcnt;
    shreg_n   = shreg;
    scl_n     = scl;
    sda_low_n = sda_low;
    nack_n    = nack;
    end_n     = end_r;
    ack_n     = ack_r;
    busy_n    = busy_r;

    if (state == START || state == BIT ||
        state == STOP) begin
      div_n = tick ? '0 : div + 1'b1;
    end

    case (state)
      IDLE: begin
        if (iGO && !end_r) begin
          state_n = START;
          div_n   = '0;
          q_n     = '0;
          bcnt_n  = '0;
          shreg_n = iDATA;
          nack_n  = 1'b0;
          ack_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (q == 2'd0) begin
            sda_low_n = 1'b1;
            scl_n     = 1'b1;
            q_n       = 2'd1;
          end else begin
            scl_n   = 1'b0;
            q_n     = 2'd0;
            bcnt_n  = '0;
            state_n = BIT;
          end
        end
      end
      BIT: begin
        if (tick) begin
          q_n = q + 2'd1;
          case (q)
            2'd0: begin
              scl_n     = 1'b0;
              sda_low_n = ack_slot ? 1'b0 : !shreg[23];
            end
            2'd1: scl_n = 1'b1;
            2'd2: begin
              // Slave drives the ACK; a released (high) line is a NACK.
              if (ack_slot && I2C_SDAT) nack_n = 1'b1;
            end
            default: begin
              scl_n = 1'b0;
              if (!ack_slot) shreg_n = {shreg[22:0], 1'b0};
              if (bcnt == 5'd26) begin
                state_n = STOP;
                q_n     = 2'd0;
              end else begin
                bcnt_n = bcnt + 5'd1;
              end
            end
          endcase
        end
      end
      STOP: begin
        if (tick) begin
          case (q)
            2'd0: begin
              sda_low_n = 1'b1;
              scl_n     = 1'b0;
              q_n       = 2'd1;
            end
            2'd1: begin
              scl_n = 1'b1;
              q_n   = 2'd2;
            end
            default: begin
              sda_low_n = 1'b0;
              q_n       = 2'd0;
              state_n   = DONE;
              end_n     = 1'b1;
              busy_n    = 1'b0;
              ack_n     = nack;
            end
          endcase
        end
      end
      DONE: begin
        if (!iGO) begin
          end_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
